// File: rtl/clk_en_rst_gen_if.sv
// rtl/clk_en_rst_gen_if.sv - control and status bundle for the clock-enable / reset-sequencing generator
interface clk_en_rst_gen_if #(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = 8
);
  logic                    en;
  logic [NUM_CH*DIV_W-1:0] div;
  logic                    sw_rst;
  logic [NUM_CH-1:0]       ce;
  logic [NUM_CH-1:0]       lvl;
  logic [NUM_CH-1:0]       rst_out;
  logic                    seq_done;
  logic [NUM_CH-1:0]       cfg_err;

  modport master (
    output en, div, sw_rst,
    input  ce, lvl, rst_out, seq_done, cfg_err
  );

  modport slave (
    input  en, div, sw_rst,
    output ce, lvl, rst_out, seq_done, cfg_err
  );
endinterface

// File: rtl/clk_en_rst_gen.sv
// rtl/clk_en_rst_gen.sv - per-channel clock-enable dividers with staggered domain reset release
module clk_en_rst_gen #(
  parameter int NUM_CH   = 4,
  parameter int DIV_W    = 8,
  parameter int HOLD_CYC = 16,
  parameter int STAGGER  = 4
) (
  input  logic             clk,
  input  logic             rst,
  clk_en_rst_gen_if.slave  bus
);

  // Sequence counter saturates at the edge that releases the last channel.
  localparam int LAST = HOLD_CYC + (NUM_CH - 1) * STAGGER;
  localparam int SW   = $clog2(LAST + 2);

  typedef enum logic [1:0] {S_HOLD, S_RELEASE, S_RUN} state_t;

  state_t            state, state_n;
  logic [SW-1:0]     seq_cnt, seq_cnt_n;
  logic [NUM_CH-1:0] rel_n;
  logic [NUM_CH-1:0] rst_out_q;
  logic              seq_done_q;

  logic [DIV_W-1:0]  cnt_q [NUM_CH];
  logic [DIV_W-1:0]  cnt_n [NUM_CH];
  logic [DIV_W-1:0]  d_q   [NUM_CH];
  logic [DIV_W-1:0]  d_n   [NUM_CH];
  logic [NUM_CH-1:0] ce_q, ce_n;
  logic [NUM_CH-1:0] lvl_q, lvl_n;
  logic [NUM_CH-1:0] err_q, err_n;

  // Sequencer: soft reset restarts at HOLD, otherwise count edges and release channels in order.
  always_comb begin
    state_n   = state;
    seq_cnt_n = seq_cnt;
    rel_n     = '0;
    if (bus.sw_rst) begin
      state_n   = S_HOLD;
      seq_cnt_n = '0;
    end else begin
      if (seq_cnt != SW'(LAST)) seq_cnt_n = seq_cnt + SW'(1);
      for (int k = 0; k < NUM_CH; k++) begin
        rel_n[k] = (int'(seq_cnt) >= HOLD_CYC + k * STAGGER);
      end
      case (state)
        S_HOLD:    if (rel_n[0]) state_n = rel_n[NUM_CH-1] ? S_RUN : S_RELEASE;
        S_RELEASE: if (rel_n[NUM_CH-1]) state_n = S_RUN;
        default:   state_n = S_RUN;
      endcase
    end
  end

  // Per-channel divider: shadow divisor reloads on release and on wrap; divisors below 2 park the channel.
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      cnt_n[k] = cnt_q[k];
      d_n[k]   = d_q[k];
      ce_n[k]  = 1'b0;
      lvl_n[k] = lvl_q[k];
      err_n[k] = 1'b0;
      if (!rel_n[k]) begin
        cnt_n[k] = '0;
        d_n[k]   = '0;
        lvl_n[k] = 1'b0;
      end else if (rst_out_q[k] || (d_q[k] < DIV_W'(2))) begin
        d_n[k]   = bus.div[k*DIV_W +: DIV_W];
        cnt_n[k] = '0;
        lvl_n[k] = 1'b0;
        err_n[k] = (bus.div[k*DIV_W +: DIV_W] < DIV_W'(2));
      end else if (bus.en) begin
        ce_n[k]  = (cnt_q[k] == d_q[k] - DIV_W'(1));
        lvl_n[k] = (cnt_q[k] >= (d_q[k] >> 1));
        if (cnt_q[k] == d_q[k] - DIV_W'(1)) begin
          cnt_n[k] = '0;
          d_n[k]   = bus.div[k*DIV_W +: DIV_W];
          err_n[k] = (bus.div[k*DIV_W +: DIV_W] < DIV_W'(2));
        end else begin
          cnt_n[k] = cnt_q[k] + DIV_W'(1);
        end
      end
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_HOLD;
      seq_cnt    <= '0;
      rst_out_q  <= '1;
      seq_done_q <= 1'b0;
      ce_q       <= '0;
      lvl_q      <= '0;
      err_q      <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        cnt_q[k] <= '0;
        d_q[k]   <= '0;
      end
    end else begin
      state      <= state_n;
      seq_cnt    <= seq_cnt_n;
      rst_out_q  <= ~rel_n;
      seq_done_q <= rel_n[NUM_CH-1];
      ce_q       <= ce_n;
      lvl_q      <= lvl_n;
      err_q      <= err_n;
      for (int k = 0; k < NUM_CH; k++) begin
        cnt_q[k] <= cnt_n[k];
        d_q[k]   <= d_n[k];
      end
    end
  end

  assign bus.ce       = ce_q;
  assign bus.lvl      = lvl_q;
  assign bus.rst_out  = rst_out_q;
  assign bus.seq_done = seq_done_q;
  assign bus.cfg_err  = err_q;

endmodule

// File: tb/tb_clk_en_rst_gen.sv
// tb/tb_clk_en_rst_gen.sv - directed bench for clk_en_rst_gen
module tb_clk_en_rst_gen;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  int   st  [4];
  int   dv  [4];
  logic bd  [4];
  logic [3:0] lvl_hold;

  clk_en_rst_gen_if #(.NUM_CH(4), .DIV_W(8)) bus ();

  clk_en_rst_gen #(
    .NUM_CH(4), .DIV_W(8), .HOLD_CYC(16), .STAGGER(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_rst_out"}, 32'(bus.rst_out), 32'hF);
    check({tag, "_seq_done"}, 32'(bus.seq_done), 32'h0);
    check({tag, "_ce"}, 32'(bus.ce), 32'h0);
    check({tag, "_lvl"}, 32'(bus.lvl), 32'h0);
    check({tag, "_cfg_err"}, 32'(bus.cfg_err), 32'h0);
  endtask

  // m = edges since T0 (T0 itself is m=0); st[k] = edge after which the channel count sits at 0.
  task automatic check_cycle(input int m);
    logic [3:0] e_ro, e_ce, e_lvl, e_err;
    int p;
    for (int k = 0; k < 4; k++) begin
      e_ro[k]  = !(m >= 16 + 4 * k);
      e_err[k] = (m >= 16 + 4 * k) && bd[k];
      e_ce[k]  = 1'b0;
      e_lvl[k] = 1'b0;
      if (m > st[k]) begin
        p = (m - st[k] - 1) % dv[k];
        e_ce[k]  = (p == dv[k] - 1);
        e_lvl[k] = (p >= dv[k] / 2);
      end
    end
    check($sformatf("rst_out@%0d", m), 32'(bus.rst_out), 32'(e_ro));
    check($sformatf("seq_done@%0d", m), 32'(bus.seq_done), 32'(m >= 28));
    check($sformatf("ce@%0d", m), 32'(bus.ce), 32'(e_ce));
    check($sformatf("lvl@%0d", m), 32'(bus.lvl), 32'(e_lvl));
    check($sformatf("cfg_err@%0d", m), 32'(bus.cfg_err), 32'(e_err));
  endtask

  task automatic replay(input int last_m);
    st = '{16, 20, 24, 28};
    dv = '{4, 3, 6, 8};
    bd = '{1'b0, 1'b0, 1'b0, 1'b0};
    for (int m = 0; m <= last_m; m++) begin
      step();
      check_cycle(m);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst        = 1'b0;
    bus.en     = 1'b1;
    bus.sw_rst = 1'b0;
    bus.div    = {8'd8, 8'd1, 8'd5, 8'd4};

    // hardware reset held three edges
    for (int i = 0; i < 3; i++) step();
    check_reset("reset");
    rst = 1'b0;
    rst = 1'b1;

    // release sequence, ch0 div 4, ch1 5->3 mid-period, ch2 bad then 6, ch3 8
    st = '{16, 20, 1000, 28};
    dv = '{4, 5, 6, 8};
    bd = '{1'b0, 1'b0, 1'b1, 1'b0};
    for (int m = 0; m <= 62; m++) begin
      step();
      check_cycle(m);
      if (m == 21) bus.div[15:8] = 8'd3;
      if (m == 25) begin st[1] = 25; dv[1] = 3; end
      if (m == 40) begin bus.div[23:16] = 8'd6; bd[2] = 1'b0; st[2] = 41; end
    end

    // en low for 7 edges with ch0 count at 2
    lvl_hold = bus.lvl;
    bus.en = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step();
      check($sformatf("en_off_ce%0d", i), 32'(bus.ce), 32'h0);
      check($sformatf("en_off_lvl%0d", i), 32'(bus.lvl), 32'(lvl_hold));
    end
    bus.en = 1'b1;
    step();
    check("en_back_ce0_a", 32'(bus.ce[0]), 32'h0);
    check("en_back_lvl0_a", 32'(bus.lvl[0]), 32'h1);
    step();
    check("en_back_ce0_b", 32'(bus.ce[0]), 32'h1);
    check("en_back_lvl0_b", 32'(bus.lvl[0]), 32'h1);

    // soft reset pulse in RUN, then identical replay
    bus.sw_rst = 1'b1;
    step();
    check_reset("sw_rst");
    bus.sw_rst = 1'b0;
    replay(22);

    // hard reset after ch1 release, then full restart
    rst = 1'b0;
    step();
    check_reset("mid_rel");
    rst = 1'b1;
    replay(30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
